// File: rtl/sha3_pkg.sv
// sha3_pkg
//   Shared Keccak types and helpers for the theta datapath.
//   lane_t  : one 64-bit lane
//   plane_t : five lanes indexed by column x (packed, lane x at index x)
//   rotl64  : 64-bit rotate-left, pure wire permutation
//   theta_gen_state_e : FSM encoding for sha3_theta_elt_generator
package sha3_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [4:0] plane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    MIX   = 2'd2,
    EMIT  = 2'd3
  } theta_gen_state_e;

  function automatic lane_t rotl64(lane_t v, int n);
    int s;
    s = n & 63;
    // s==0 makes the right shift 64, which yields zero, so v passes unchanged.
    return (v << s) | (v >> (64 - s));
  endfunction

endpackage

// File: rtl/sha3_theta_mixer.sv
// sha3_theta_mixer
//   Combinational theta column mix: elt[x] = C[(x+4)%5] ^ rotl64(C[(x+1)%5], 1).
//   Kept free of state so a fully combinational theta can reuse it.
// Ports
//   c_i   : column parities C[0..4]
//   elt_o : per-column theta deltas
module sha3_theta_mixer
  import sha3_pkg::*;
(
  input  plane_t c_i,
  output plane_t elt_o
);

  for (genvar x = 0; x < 5; x++) begin : g_col
    assign elt_o[x] = c_i[(x + 4) % 5] ^ rotl64(c_i[(x + 1) % 5], 1);
  end

endmodule

// File: rtl/sha3_theta_elt_generator.sv
// sha3_theta_elt_generator
//   Captures a 5x5x64 Keccak state, folds rows into column parities
//   ROWS_PER_CYCLE rows per clock, mixes them into theta deltas and emits a
//   one-cycle sample strobe alongside the untouched state.
// Ports
//   clk            : clock, posedge
//   rst            : synchronous active-low reset
//   in_valid       : input state valid
//   in_ready       : high only while IDLE (registered)
//   isa..ise       : input rows y=0..4, lane index = column x
//   osa..ose       : captured state rows, held until next capture
//   elt            : theta column deltas, held until next MIX
//   sample         : one-cycle strobe, high in EMIT
//   parity         : accumulated C[x]; present only with SHA3_THETA_ELT_PARITY_OUT_EN
// Configuration
//   SHA3_THETA_ELT_PARITY_OUT_EN : exposes the parity register as an output port.
//
// state | meaning
// IDLE  | in_ready high, waiting for a state to capture
// ACCUM | folding captured rows into the parity register
// MIX   | parity final; elt registered from the mixer
// EMIT  | sample high for this single cycle
module sha3_theta_elt_generator
  import sha3_pkg::*;
#(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  plane_t isa,
  input  plane_t isb,
  input  plane_t isc,
  input  plane_t isd,
  input  plane_t ise,
  output plane_t osa,
  output plane_t osb,
  output plane_t osc,
  output plane_t osd,
  output plane_t ose,
  output plane_t elt,
  output logic   sample
`ifdef SHA3_THETA_ELT_PARITY_OUT_EN
  ,
  output plane_t parity
`endif
);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 5)) begin : g_bad_rpc
    $error("sha3_theta_elt_generator: ROWS_PER_CYCLE must be 1 or 5");
  end

  localparam logic [2:0] RPC = 3'(ROWS_PER_CYCLE);

  theta_gen_state_e state_q;
  logic [2:0]       row_q;
  logic             in_ready_q;
  logic             sample_q;
  plane_t           osa_q, osb_q, osc_q, osd_q, ose_q;
  plane_t           c_q;
  plane_t           elt_q;

  plane_t           rows_w [5];
  plane_t           c_d;
  plane_t           mix_elt;
  logic             last_fold;

  assign rows_w[0] = osa_q;
  assign rows_w[1] = osb_q;
  assign rows_w[2] = osc_q;
  assign rows_w[3] = osd_q;
  assign rows_w[4] = ose_q;

  // Fold the window of rows [row_q, row_q+RPC) into the running parity.
  always_comb begin
    c_d = c_q;
    for (int k = 0; k < 5; k++) begin
      if (k >= int'(row_q) && k < int'(row_q) + ROWS_PER_CYCLE) begin
        c_d = c_d ^ rows_w[k];
      end
    end
  end

  assign last_fold = (int'(row_q) + ROWS_PER_CYCLE) >= 5;

  sha3_theta_mixer u_mixer (
    .c_i   (c_q),
    .elt_o (mix_elt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      in_ready_q <= 1'b0;
      sample_q   <= 1'b0;
      osa_q      <= '0;
      osb_q      <= '0;
      osc_q      <= '0;
      osd_q      <= '0;
      ose_q      <= '0;
      c_q        <= '0;
      elt_q      <= '0;
    end else begin
      sample_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            osa_q      <= isa;
            osb_q      <= isb;
            osc_q      <= isc;
            osd_q      <= isd;
            ose_q      <= ise;
            c_q        <= '0;
            row_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          c_q   <= c_d;
          row_q <= row_q + RPC;
          if (last_fold) begin
            state_q <= MIX;
          end
        end
        MIX: begin
          elt_q    <= mix_elt;
          sample_q <= 1'b1;
          state_q  <= EMIT;
        end
        EMIT: begin
          // Raising in_ready here makes the cycle after EMIT able to accept.
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign sample   = sample_q;
  assign osa      = osa_q;
  assign osb      = osb_q;
  assign osc      = osc_q;
  assign osd      = osd_q;
  assign ose      = ose_q;
  assign elt      = elt_q;
`ifdef SHA3_THETA_ELT_PARITY_OUT_EN
  assign parity   = c_q;
`endif

endmodule

// File: tb/tb_sha3_theta_elt_generator.sv
// Bench for sha3_theta_elt_generator: one instance with ROWS_PER_CYCLE=1 and
// one with ROWS_PER_CYCLE=5, sharing clock, reset and row inputs.
module tb_sha3_theta_elt_generator;
  import sha3_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   v1  = 1'b0;
  logic   v5  = 1'b0;
  plane_t ia = '0, ib = '0, ic = '0, id = '0, ie = '0;

  logic   r1, s1, r5, s5;
  plane_t oa1, ob1, oc1, od1, oe1, e1;
  plane_t oa5, ob5, oc5, od5, oe5, e5;
`ifdef SHA3_THETA_ELT_PARITY_OUT_EN
  plane_t p1, p5;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sha3_theta_elt_generator #(.ROWS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
    .isa(ia), .isb(ib), .isc(ic), .isd(id), .ise(ie),
    .osa(oa1), .osb(ob1), .osc(oc1), .osd(od1), .ose(oe1),
    .elt(e1), .sample(s1)
`ifdef SHA3_THETA_ELT_PARITY_OUT_EN
    , .parity(p1)
`endif
  );

  sha3_theta_elt_generator #(.ROWS_PER_CYCLE(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5),
    .isa(ia), .isb(ib), .isc(ic), .isd(id), .ise(ie),
    .osa(oa5), .osb(ob5), .osc(oc5), .osd(od5), .ose(oe5),
    .elt(e5), .sample(s5)
`ifdef SHA3_THETA_ELT_PARITY_OUT_EN
    , .parity(p5)
`endif
  );

  int errs   = 0;
  int checks = 0;

  typedef struct {
    plane_t a, b, c, d, e, elt, par;
    int     at;
  } exp_t;

  exp_t q1[$];
  exp_t q5[$];

  function automatic void chk(string nm, plane_t act, plane_t exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chkb(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void chki(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Monitors: pop and compare whenever a DUT raises sample.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (s1 === 1'b1) begin
        if (q1.size() == 0) begin
          checks++; errs++;
          $display("FAIL sample1_unexpected: got sample=1 expected no sample (cycle %0d)", cyc);
        end else begin
          x = q1.pop_front();
          chki("latency1", cyc, x.at);
          chk("elt1", e1, x.elt);
          chk("osa1", oa1, x.a);
          chk("osb1", ob1, x.b);
          chk("osc1", oc1, x.c);
          chk("osd1", od1, x.d);
          chk("ose1", oe1, x.e);
`ifdef SHA3_THETA_ELT_PARITY_OUT_EN
          chk("parity1", p1, x.par);
`endif
        end
      end
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (s5 === 1'b1) begin
        if (q5.size() == 0) begin
          checks++; errs++;
          $display("FAIL sample5_unexpected: got sample=1 expected no sample (cycle %0d)", cyc);
        end else begin
          x = q5.pop_front();
          chki("latency5", cyc, x.at);
          chk("elt5", e5, x.elt);
          chk("osa5", oa5, x.a);
          chk("osb5", ob5, x.b);
          chk("osc5", oc5, x.c);
          chk("osd5", od5, x.d);
          chk("ose5", oe5, x.e);
`ifdef SHA3_THETA_ELT_PARITY_OUT_EN
          chk("parity5", p5, x.par);
`endif
        end
      end
    end
  end

  // Issue one job (called at a negedge). Returns the accepting edge index.
  task automatic send(input bit five, input bit push, input plane_t a, b, c, d, e,
                      input plane_t elt_exp, output int at);
    int   n;
    exp_t x;
    n = 0;
    while (((five ? r5 : r1) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errs++;
      $display("FAIL ready_timeout: got in_ready=0 for 50 cycles expected 1");
      at = -1;
      return;
    end
    ia = a; ib = b; ic = c; id = d; ie = e;
    if (five) v5 = 1'b1; else v1 = 1'b1;
    at = cyc + 1;
    if (push) begin
      x = '{a, b, c, d, e, elt_exp, a ^ b ^ c ^ d ^ e, at + (five ? 2 : 6)};
      if (five) q5.push_back(x); else q1.push_back(x);
    end
    @(negedge clk);
    v1 = 1'b0;
    v5 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q5.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errs++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q1.size(), q5.size());
    end
    @(negedge clk);
  endtask

  initial begin
    plane_t z, a0, ones, e2, ex, eb, exb, c1, ec;
    int     at;

    z    = '0;
    a0   = '0; a0[0] = 64'h1;
    ones = '1;
    e2   = '0; e2[2] = 64'h8000_0000_0000_0000;
    eb   = '0; eb[3] = 64'hA5;
    c1   = '0; c1[1] = 64'h3;

    // Reset state
    repeat (3) @(negedge clk);
    chkb("rst_ready1", r1, 1'b0);
    chkb("rst_sample1", s1, 1'b0);
    chk("rst_elt1", e1, z);
    chk("rst_osa1", oa1, z);
    chkb("rst_ready5", r5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chkb("rel_ready1", r1, 1'b1);
    chkb("rel_ready5", r5, 1'b1);

    // All-zero state
    send(1'b0, 1'b1, z, z, z, z, z, z, at);
    drain();

    // Single bit in isa[0]
    ex = '0; ex[1] = 64'h1; ex[4] = 64'h2;
    send(1'b0, 1'b1, a0, z, z, z, z, ex, at);
    drain();

    // All ones -> zero deltas
    send(1'b0, 1'b1, ones, ones, ones, ones, ones, z, at);
    drain();

    // MSB of ise[2] wraps via the rotate
    ex = '0; ex[3] = 64'h8000_0000_0000_0000; ex[1] = 64'h1;
    send(1'b0, 1'b1, z, z, z, z, e2, ex, at);
    drain();

    // Five-rows-per-cycle instance
    exb = '0; exb[2] = 64'h14A; exb[4] = 64'hA5;
    send(1'b1, 1'b1, z, eb, z, z, z, exb, at);
    drain();
    ex = '0; ex[1] = 64'h1; ex[4] = 64'h2;
    send(1'b1, 1'b1, a0, z, z, z, z, ex, at);
    drain();

    // in_valid held high: one accept every 8 cycles
    ec = '0; ec[0] = 64'h6; ec[2] = 64'h3;
    while (r1 !== 1'b1) @(negedge clk);
    ia = z; ib = z; ic = c1; id = z; ie = z;
    v1 = 1'b1;
    at = cyc + 1;
    for (int k = 0; k < 3; k++) q1.push_back('{z, z, c1, z, z, ec, c1, at + 8 * k + 6});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chkb("ready_stream", r1, ((cyc - at) % 8) == 7);
    end
    @(negedge clk);
    v1 = 1'b0;
    drain();

    // Reset during the third ACCUM cycle aborts the job
    send(1'b0, 1'b0, a0, a0, z, z, z, z, at);
    while (cyc < at + 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chkb("abort_sample", s1, 1'b0);
    chkb("abort_ready", r1, 1'b0);
    chk("abort_elt", e1, z);
    chk("abort_osa", oa1, z);
    chk("abort_osb", ob1, z);
    rst = 1'b1;
    @(negedge clk);
    chkb("abort_ready_rel", r1, 1'b1);
    repeat (8) @(negedge clk);

    // Recovery after abort
    ex = '0; ex[1] = 64'h1; ex[4] = 64'h2;
    send(1'b0, 1'b1, a0, z, z, z, z, ex, at);
    drain();

    chki("pending1", q1.size(), 0);
    chki("pending5", q5.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
